// File: rtl/wb_grf_if.sv
// W-stage write-back bundle: M/W pipeline outputs in, decode read ports and
// forwarding/retire results out.
interface wb_grf_if;
    logic [31:0] W_PC;
    logic [31:0] W_instr;
    logic [31:0] W_CAL_res;
    logic [31:0] W_DM_RD;
    logic [31:0] W_RD2;
    logic [2:0]  W_wd_sel;
    logic [2:0]  W_ld_type;
    logic        W_we;
    logic [4:0]  W_a3;
    logic [4:0]  D_A1;
    logic [4:0]  D_A2;
    logic [31:0] D_RD1;
    logic [31:0] D_RD2;
    logic [31:0] W_WD;
    logic [31:0] retire_cnt;

    modport master (
        output W_PC, W_instr, W_CAL_res, W_DM_RD, W_RD2, W_wd_sel, W_ld_type,
               W_we, W_a3, D_A1, D_A2,
        input  D_RD1, D_RD2, W_WD, retire_cnt
    );

    modport slave (
        input  W_PC, W_instr, W_CAL_res, W_DM_RD, W_RD2, W_wd_sel, W_ld_type,
               W_we, W_a3, D_A1, D_A2,
        output D_RD1, D_RD2, W_WD, retire_cnt
    );
endinterface

// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file with write-through
// bypass on both decode read ports and a retired-instruction counter.
`ifndef fwd_src_CALres
`define fwd_src_CALres 3'd0
`endif
`ifndef fwd_src_DM_RD
`define fwd_src_DM_RD 3'd1
`endif
`ifndef fwd_src_RD2
`define fwd_src_RD2 3'd2
`endif
`ifndef fwd_src_PC8
`define fwd_src_PC8 3'd3
`endif

module wb_grf #(
    parameter logic [31:0] GP_INIT = 32'h0000_0000,
    parameter logic [31:0] SP_INIT = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    reset,
    wb_grf_if.slave bus
);
    logic [31:0] r_grf [0:31];
    logic [31:0] r_retire_cnt;
    logic [31:0] w_ld_val;
    logic [31:0] w_wd;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_wr_en;

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  ofs,
        input logic [2:0]  ld_type
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (ofs)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        // offset bit 0 is deliberately ignored for halfword loads
        half_v = ofs[1] ? word[31:16] : word[15:0];
        case (ld_type)
            3'd1:    res = {24'h00_0000, byte_v};
            3'd2:    res = {{24{byte_v[7]}}, byte_v};
            3'd3:    res = {16'h0000, half_v};
            3'd4:    res = {{16{half_v[15]}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Load extension and write-back data selection.
    always_comb begin
        w_ld_val = load_extend(bus.W_DM_RD, bus.W_CAL_res[1:0], bus.W_ld_type);
        case (bus.W_wd_sel)
            `fwd_src_CALres: w_wd = bus.W_CAL_res;
            `fwd_src_DM_RD:  w_wd = w_ld_val;
            `fwd_src_RD2:    w_wd = bus.W_RD2;
            `fwd_src_PC8:    w_wd = bus.W_PC + 32'd8;
            default:         w_wd = 32'h0000_0000;
        endcase
    end

    // Reset gates the write enable so bypass is also suppressed while in reset.
    assign w_wr_en = reset & bus.W_we & (bus.W_a3 != 5'd0);

    // Decode read ports with write-through bypass from the W stage.
    always_comb begin
        if (w_wr_en && (bus.D_A1 == bus.W_a3)) begin
            w_rd1 = w_wd;
        end else begin
            w_rd1 = r_grf[bus.D_A1];
        end
        if (w_wr_en && (bus.D_A2 == bus.W_a3)) begin
            w_rd2 = w_wd;
        end else begin
            w_rd2 = r_grf[bus.D_A2];
        end
    end

    // Register file storage; $0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_grf[i] <= (i == 28) ? GP_INIT :
                            (i == 29) ? SP_INIT : 32'h0000_0000;
            end
        end else if (w_wr_en) begin
            r_grf[bus.W_a3] <= w_wd;
        end
    end

    // Retired-instruction counter; bubbles are all-zero instruction words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= 32'h0000_0000;
        end else if (bus.W_instr != 32'h0000_0000) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.W_WD       = w_wd;
    assign bus.D_RD1      = w_rd1;
    assign bus.D_RD2      = w_rd2;
    assign bus.retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: reset contents, load extension table,
// write/bypass sequences, retire counter and asynchronous reset.
module tb_wb_grf;
    localparam logic [2:0]  SEL_CAL = 3'd0;
    localparam logic [2:0]  SEL_DM  = 3'd1;
    localparam logic [2:0]  SEL_RD2 = 3'd2;
    localparam logic [2:0]  SEL_PC8 = 3'd3;
    localparam logic [31:0] GP      = 32'h0000_1800;
    localparam logic [31:0] SP      = 32'h0000_2FFC;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [2:0]  ld;
        logic [31:0] cal;
        logic [31:0] dm;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    wb_grf_if bus();

    wb_grf #(.GP_INIT(GP), .SP_INIT(SP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] reset_val(input int a);
        return (a == 28) ? GP : (a == 29) ? SP : 32'h0000_0000;
    endfunction

    task automatic expect_val(input string n, input logic [31:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_out(input logic [31:0] act);
        sb_t s;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h with nothing expected", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic idle();
        bus.W_PC      = 32'h0000_0000;
        bus.W_instr   = 32'h0000_0000;
        bus.W_CAL_res = 32'h0000_0000;
        bus.W_DM_RD   = 32'h0000_0000;
        bus.W_RD2     = 32'h0000_0000;
        bus.W_wd_sel  = SEL_CAL;
        bus.W_ld_type = 3'd0;
        bus.W_we      = 1'b0;
        bus.W_a3      = 5'd0;
        bus.D_A1      = 5'd0;
        bus.D_A2      = 5'd0;
    endtask

    task automatic add_vec(input string n, input logic [2:0] sel, input logic [2:0] ld,
                           input logic [31:0] cal, input logic [31:0] dm,
                           input logic [31:0] rd2, input logic [31:0] pc,
                           input logic [31:0] exp);
        vec_t v;
        v.name = n; v.sel = sel; v.ld = ld; v.cal = cal; v.dm = dm;
        v.rd2 = rd2; v.pc = pc; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("lb_off2",    SEL_DM,  3'd2, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_FFFF);
        add_vec("lbu_off3",   SEL_DM,  3'd1, 32'h0000_0003, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_0080);
        add_vec("lh_off2",    SEL_DM,  3'd4, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_80FF);
        add_vec("lhu_off0",   SEL_DM,  3'd3, 32'h0000_0000, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_7F01);
        add_vec("word",       SEL_DM,  3'd0, 32'h0000_0001, 32'h80FF_7F01, 32'h0, 32'h0, 32'h80FF_7F01);
        add_vec("lbu_off1",   SEL_DM,  3'd1, 32'h0000_0001, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_007F);
        add_vec("lb_off3",    SEL_DM,  3'd2, 32'h0000_1003, 32'h80FF_7F01, 32'h0, 32'h0, 32'hFFFF_FF80);
        add_vec("lhu_off3",   SEL_DM,  3'd3, 32'h0000_0003, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_80FF);
        add_vec("lh_off0",    SEL_DM,  3'd4, 32'h0000_0000, 32'h80FF_7F01, 32'h0, 32'h0, 32'h0000_7F01);
        add_vec("ld_type6",   SEL_DM,  3'd6, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 32'h0, 32'h80FF_7F01);
        add_vec("sel_cal",    SEL_CAL, 3'd1, 32'hA5A5_0003, 32'h80FF_7F01, 32'h0, 32'h0, 32'hA5A5_0003);
        add_vec("sel_rd2",    SEL_RD2, 3'd0, 32'h1111_1111, 32'h2222_2222, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D);
        add_vec("sel_pc8",    SEL_PC8, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0000_3000, 32'h0000_3008);
        add_vec("pc8_wrap",   SEL_PC8, 3'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0004);
        add_vec("sel_bad5",   3'd5,    3'd0, 32'h1234_5678, 32'h8765_4321, 32'h5555_5555, 32'h100, 32'h0000_0000);
        add_vec("sel_bad7",   3'd7,    3'd0, 32'h1234_5678, 32'h8765_4321, 32'h5555_5555, 32'h100, 32'h0000_0000);

        idle();
        // Reset pulse with the clock stopped.
        #2;
        reset = 1'b0;
        #2;
        for (int a = 0; a < 32; a++) begin
            bus.D_A1 = 5'(a);
            bus.D_A2 = 5'(31 - a);
            #1;
            expect_val($sformatf("reset_rd1_r%0d", a), reset_val(a));
            check_out(bus.D_RD1);
            expect_val($sformatf("reset_rd2_r%0d", 31 - a), reset_val(31 - a));
            check_out(bus.D_RD2);
        end
        expect_val("reset_retire_cnt", 32'h0000_0000);
        check_out(bus.retire_cnt);
        reset = 1'b1;
        #1;
        clk_en = 1'b1;
        @(negedge clk);

        // Combinational write-back value table.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.W_wd_sel  = vecs[i].sel;
            bus.W_ld_type = vecs[i].ld;
            bus.W_CAL_res = vecs[i].cal;
            bus.W_DM_RD   = vecs[i].dm;
            bus.W_RD2     = vecs[i].rd2;
            bus.W_PC      = vecs[i].pc;
            expect_val(vecs[i].name, vecs[i].exp);
            #1;
            check_out(bus.W_WD);
            @(negedge clk);
        end
        idle();

        // Write to $5 with both ports bypassing in the same cycle.
        bus.W_we = 1'b1; bus.W_a3 = 5'd5; bus.W_wd_sel = SEL_CAL;
        bus.W_CAL_res = 32'h1234_5678; bus.D_A1 = 5'd5; bus.D_A2 = 5'd5;
        expect_val("bypass_rd1", 32'h1234_5678);
        expect_val("bypass_rd2", 32'h1234_5678);
        #1;
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        @(posedge clk); #1;
        bus.W_we = 1'b0;
        expect_val("stored_rd1_r5", 32'h1234_5678);
        expect_val("stored_rd2_r5", 32'h1234_5678);
        #1;
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        @(negedge clk);

        // Write $6 while port 1 reads $5 from storage.
        bus.W_we = 1'b1; bus.W_a3 = 5'd6; bus.W_CAL_res = 32'h0BAD_BEEF;
        bus.D_A1 = 5'd5; bus.D_A2 = 5'd6;
        expect_val("nobypass_rd1_r5", 32'h1234_5678);
        expect_val("bypass_rd2_r6", 32'h0BAD_BEEF);
        #1;
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        @(negedge clk);

        // $0 is never written.
        bus.W_we = 1'b1; bus.W_a3 = 5'd0; bus.W_CAL_res = 32'hFFFF_FFFF;
        bus.D_A1 = 5'd0; bus.D_A2 = 5'd6;
        expect_val("r0_wd", 32'hFFFF_FFFF);
        expect_val("r0_before", 32'h0000_0000);
        #1;
        check_out(bus.W_WD);
        check_out(bus.D_RD1);
        @(posedge clk); #1;
        bus.W_we = 1'b0;
        expect_val("r0_after", 32'h0000_0000);
        expect_val("stored_r6", 32'h0BAD_BEEF);
        #1;
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        @(negedge clk);

        // jal link value into $31.
        bus.W_we = 1'b1; bus.W_a3 = 5'd31; bus.W_wd_sel = SEL_PC8;
        bus.W_PC = 32'h0000_3000; bus.D_A1 = 5'd31;
        expect_val("jal_wd", 32'h0000_3008);
        #1;
        check_out(bus.W_WD);
        @(posedge clk); #1;
        bus.W_we = 1'b0; bus.W_PC = 32'h0000_0000;
        expect_val("jal_r31", 32'h0000_3008);
        #1;
        check_out(bus.D_RD1);
        @(negedge clk);
        idle();

        // Counter: 3 instructions, 2 bubbles, 1 instruction.
        expect_val("retire_start", 32'h0000_0000);
        check_out(bus.retire_cnt);
        for (int k = 0; k < 6; k++) begin
            bus.W_instr = (k == 3 || k == 4) ? 32'h0000_0000 : 32'h2000_0000 + 32'(k);
            @(negedge clk);
        end
        bus.W_instr = 32'h0000_0000;
        expect_val("retire_cnt4", 32'h0000_0004);
        #1;
        check_out(bus.retire_cnt);
        @(negedge clk);

        // Asynchronous reset between edges drops a pending write to $7.
        bus.W_instr = 32'h0000_0011; bus.W_we = 1'b1; bus.W_a3 = 5'd7;
        bus.W_wd_sel = SEL_CAL; bus.W_CAL_res = 32'hDEAD_BEEF;
        bus.D_A1 = 5'd7; bus.D_A2 = 5'd28;
        expect_val("pending_bypass_r7", 32'hDEAD_BEEF);
        #1;
        check_out(bus.D_RD1);
        #1;
        reset = 1'b0;
        #1;
        expect_val("async_retire_cnt", 32'h0000_0000);
        expect_val("async_rd1_nobypass", 32'h0000_0000);
        expect_val("async_rd2_gp", GP);
        expect_val("async_wd_comb", 32'hDEAD_BEEF);
        check_out(bus.retire_cnt);
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        check_out(bus.W_WD);
        @(posedge clk); #1;
        expect_val("reset_held_r7", 32'h0000_0000);
        check_out(bus.D_RD1);
        @(negedge clk);
        idle();
        reset = 1'b1;
        bus.D_A1 = 5'd7; bus.D_A2 = 5'd5;
        #1;
        expect_val("after_reset_r7", 32'h0000_0000);
        expect_val("after_reset_r5", 32'h0000_0000);
        expect_val("after_reset_cnt", 32'h0000_0000);
        check_out(bus.D_RD1);
        check_out(bus.D_RD2);
        check_out(bus.retire_cnt);
        bus.D_A1 = 5'd29;
        #1;
        expect_val("after_reset_sp", SP);
        check_out(bus.D_RD1);

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file for the five-stage MIPS pipeline. It sits directly downstream of the M/W pipeline register and consumes its W-stage outputs: PC, instruction, ALU result, raw data-memory word and store data. It extends load data, selects the write-back value and writes it into the 32×32 register file. The decode stage reads the file through two combinational read ports with write-through bypass.

## Interface
Parameters:
- GP_INIT, 32'h0000_0000, reset value of $28
- SP_INIT, 32'h0000_0000, reset value of $29

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears state immediately when low
- W_PC  in  32  PC of the instruction in W
- W_instr  in  32  instruction in W; 32'h0 denotes a bubble
- W_CAL_res  in  32  ALU/address result; bits [1:0] give the load byte offset
- W_DM_RD  in  32  raw aligned word read from data memory
- W_RD2  in  32  rt value carried to W
- W_wd_sel  in  3  write-data source, encoded with the `fwd_src_CALres`/`fwd_src_DM_RD`/`fwd_src_RD2`/`fwd_src_PC8` macros from header.v
- W_ld_type  in  3  0 word, 1 lbu, 2 lb, 3 lhu, 4 lh; 5–7 treated as word
- W_we  in  1  register write enable
- W_a3  in  5  destination register
- D_A1, D_A2  in  5 each  D-stage read addresses
- D_RD1, D_RD2  out  32 each  read data, bypassed
- W_WD  out  32  final write-back data; also the W-stage forwarding value
- retire_cnt  out  32  count of non-bubble instructions that left W

## Operation
- Load extension operates on W_DM_RD, with b = W_CAL_res[1:0] and h = W_CAL_res[1]:
  - word: unchanged.
  - lbu / lb: byte b, zero-extended / sign-extended.
  - lhu / lh: halfword h (h=0 → bits [15:0], h=1 → bits [31:16]), zero-extended / sign-extended.
  - W_CAL_res[0] is ignored for halfwords. Misalignment is not checked.
- W_WD selection:
  - CALres → W_CAL_res.
  - DM_RD → the extended load value.
  - RD2 → W_RD2.
  - PC8 → W_PC + 32'd8, modulo 2^32.
  - Any other code → 32'h0.
- Register write: when W_we=1 and W_a3≠0, reg[W_a3] ← W_WD. Writes to $0 are discarded, and $0 always reads 0.
- Read ports: D_RDn = W_WD if (reset high, W_we=1, W_a3≠0, D_An==W_a3); otherwise D_RDn = reg[D_An].
  - Both ports may bypass in the same cycle.
  - D_A1==D_A2 returns identical data on both ports.
- Retire counter: increments by 1 on each posedge where W_instr≠32'h0. It wraps from 32'hFFFF_FFFF to 0.
- Reset behaviour (reset low, asynchronous):
  - All registers → 0, except $28 → GP_INIT and $29 → SP_INIT.
  - retire_cnt → 0.
  - Writes are blocked and bypass is suppressed, so D_RD1 and D_RD2 show the reset contents.
  - W_WD stays purely combinational from its inputs.
- Reset deassertion is synchronised by the surrounding design. The first write is allowed on the first posedge with reset high.

## Timing
- W_WD, D_RD1 and D_RD2 are combinational from the current inputs, with zero latency.
- A write issued at posedge N is visible:
  - via bypass during the cycle before edge N;
  - from storage from edge N onward.
- A decode read of the register W is writing in the same cycle returns the new value. The W→D hazard therefore needs no stall.
- retire_cnt is registered: an instruction present in W during cycle N is counted after edge N.
- Reset assertion takes effect within the same cycle, with no clock edge needed. A reset arriving mid-pipeline loses any write pending at the next edge.

## Test plan
- Reset: pulse reset low with no clock → every D_A reads 0 except $28=GP_INIT and $29=SP_INIT; retire_cnt=0.
- Write and bypass: W_we=1, W_a3=5, wd_sel=CALres, W_CAL_res=32'h1234_5678, D_A1=D_A2=5 → D_RD1=D_RD2=32'h1234_5678 before the edge; after the edge the same value is read with W_we=0.
- $0 protection: W_we=1, W_a3=0, data 32'hFFFF_FFFF → W_WD=32'hFFFF_FFFF, D_RD1 for $0=0 before and after the edge.
- Load extension, with W_DM_RD=32'h80FF_7F01 and wd_sel=DM_RD:
  - lb at offset 2 → 32'hFFFF_FFFF.
  - lbu at offset 3 → 32'h0000_0080.
  - lh at offset 2 → 32'hFFFF_80FF.
  - lhu at offset 0 → 32'h0000_7F01.
  - word → 32'h80FF_7F01.
- PC8 (jal): W_PC=32'h0000_3000, wd_sel=PC8, W_a3=31 → W_WD=32'h0000_3008 and $31=32'h0000_3008 after the edge.
- Counter and async reset: clock 3 non-zero instructions, 2 bubbles, then 1 non-zero instruction → retire_cnt=4; drop reset between edges → retire_cnt=0 immediately and a pending write to $7 is absent.
